li_expander: RTL and testbench
==============================

// Module: li_expander
// PURPOSE
// - Constant materializer: the encode-side counterpart of the immediate generator.
//   It takes a destination register and a 32-bit constant, and emits the RV32I
//   instruction sequence (LUI and/or ADDI) that loads that constant.
// - Used by the boot/test instruction injector to feed the fetch path with
//   generated "li rd, value" sequences.
// - Input and output both use valid/ready handshakes; outputs are registered.
// PARAMETERS
// - OPT_SHORT  default 1  1: use one-instruction forms when possible; 0: always emit LUI+ADDI
// PORTS
// - i_clk     in   1   clock, all state on rising edge
// - i_rst_n   in   1   reset, asynchronous assert, active-low
// - i_valid   in   1   request valid
// - o_ready   out  1   request accepted when i_valid & o_ready
// - i_rd      in   5   destination register index
// - i_value   in   32  constant to materialize
// - o_valid   out  1   o_inst valid
// - i_ready   in   1   consumer accepts o_inst when o_valid & i_ready
// - o_inst    out  32  encoded instruction
// - o_last    out  1   o_inst is the final instruction of the sequence
// BEHAVIOUR
// - Reset (async, i_rst_n=0): state=IDLE, o_valid=0, o_inst=0, o_last=0,
//   latched rd/value cleared. o_ready=1 after reset is released.
// - Split: lo=value[11:0], hi=(value[31:12]+value[11]) mod 2^20. LUI hi then ADDI lo
//   reproduces value mod 2^32; the carry from value[11] compensates ADDI sign-extension.
// - Encodings:
//   - LUI  = {hi, rd, 7'b0110111}
//   - ADDI = {lo, rs1, 3'b000, rd, 7'b0010011}
//   - rs1 = x0 if ADDI is alone, rs1 = rd if ADDI follows LUI
// - Form selection, in priority order:
//   - rd==0: single NOP 32'h00000013, regardless of value and OPT_SHORT
//   - OPT_SHORT & value[31:11] all-0 or all-1: single ADDI rd,x0,lo
//   - OPT_SHORT & lo==0: single LUI rd,hi
//   - otherwise: LUI then ADDI rd,rd,lo
// - FSM:
//   - IDLE: o_ready=1, o_valid=0. On accept, latch rd/value, load o_inst with the
//     first instruction, set o_valid=1 and o_last per the form, go to OUT1.
//   - OUT1: o_ready=0. On transfer: if o_last, clear o_valid and o_last, go to IDLE.
//     Otherwise load ADDI, set o_last=1, go to OUT2.
//   - OUT2: o_ready=0. On transfer, clear o_valid and o_last, go to IDLE.
// - Latency: accept in cycle N gives o_valid=1 in cycle N+1. Each further transfer
//   advances one instruction per cycle.
// - Throughput: o_ready is low outside IDLE, so there is at most one request per 2 or 3 cycles.
// - Backpressure: while o_valid & !i_ready, o_inst, o_last and state hold stable.
// - i_valid is ignored while o_ready=0. i_rd and i_value need only be stable in the accept cycle.
// - Reset mid-sequence aborts it: the remaining instruction is dropped and o_valid drops immediately.
// TESTING
// - rd=5, value=32'h00000123 -> one beat 32'h12300293, o_last=1.
// - rd=10, value=32'h12345000 -> one beat LUI 32'h12345537, o_last=1.
// - rd=1, value=32'h12345FFF -> 32'h123460B7 (last=0), then 32'hFFF08093 (last=1).
// - rd=2, value=32'hFFFFF800 -> 32'h80000113. With OPT_SHORT=0: 32'h00000137 then 32'h80010113.
// - rd=0, any value -> single 32'h00000013, o_last=1.
// - Backpressure and reset:
//   - Case 3 with i_ready=0 for 3 cycles: o_inst holds 32'h123460B7, o_ready=0,
//     and a new i_valid is ignored.
//   - Assert i_rst_n=0 during OUT2: o_valid=0 in the same cycle. After release,
//     o_ready=1 and the next request encodes correctly.

Source files
------------

// File: rtl/li_expander.sv
// Materializes a 32-bit constant into an RV32I "li rd, value" sequence (LUI and/or ADDI),
// streamed one instruction per handshake with registered outputs.
module li_expander #(
    parameter bit OPT_SHORT = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_value,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic        o_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OUT1 = 2'd1,
        OUT2 = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic [31:0] enc_lui(input logic [19:0] hi, input logic [4:0] rd);
        return {hi, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] enc_addi(input logic [11:0] lo, input logic [4:0] rs1,
                                             input logic [4:0] rd);
        return {lo, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  rd_r, rd_s;
    logic [11:0] lo_r, lo_s;
    logic [31:0] inst_r, inst_s;
    logic        valid_r, valid_s;
    logic        last_r, last_s;

    logic [19:0] hi_s;
    logic        sext_s;
    logic [31:0] first_inst_s;
    logic        first_last_s;
    logic        accept_s;
    logic        xfer_s;

    assign o_ready = (state_r == IDLE);
    assign o_valid = valid_r;
    assign o_inst  = inst_r;
    assign o_last  = last_r;

    assign accept_s = i_valid & (state_r == IDLE);
    assign xfer_s   = valid_r & i_ready;

    // First instruction of the sequence; the +value[11] carry cancels ADDI sign extension.
    always_comb begin
        hi_s         = i_value[31:12] + {19'd0, i_value[11]};
        sext_s       = (i_value[31:11] == 21'h00_0000) || (i_value[31:11] == 21'h1F_FFFF);
        first_inst_s = enc_lui(hi_s, i_rd);
        first_last_s = 1'b0;
        if (i_rd == 5'd0) begin
            first_inst_s = NOP_INST;
            first_last_s = 1'b1;
        end else if (OPT_SHORT && sext_s) begin
            first_inst_s = enc_addi(i_value[11:0], 5'd0, i_rd);
            first_last_s = 1'b1;
        end else if (OPT_SHORT && (i_value[11:0] == 12'd0)) begin
            first_inst_s = enc_lui(hi_s, i_rd);
            first_last_s = 1'b1;
        end else begin
            first_inst_s = enc_lui(hi_s, i_rd);
            first_last_s = 1'b0;
        end
    end

    // Next-state and next-output logic; everything holds unless a handshake fires.
    always_comb begin
        state_s = state_r;
        rd_s    = rd_r;
        lo_s    = lo_r;
        inst_s  = inst_r;
        valid_s = valid_r;
        last_s  = last_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    rd_s    = i_rd;
                    lo_s    = i_value[11:0];
                    inst_s  = first_inst_s;
                    valid_s = 1'b1;
                    last_s  = first_last_s;
                    state_s = OUT1;
                end else begin
                    state_s = IDLE;
                end
            end
            OUT1: begin
                if (xfer_s && last_r) begin
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                    state_s = IDLE;
                end else if (xfer_s) begin
                    inst_s  = enc_addi(lo_r, rd_r, rd_r);
                    last_s  = 1'b1;
                    state_s = OUT2;
                end else begin
                    state_s = OUT1;
                end
            end
            OUT2: begin
                if (xfer_s) begin
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = OUT2;
                end
            end
            default: begin
                valid_s = 1'b0;
                last_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any sequence in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            rd_r    <= 5'd0;
            lo_r    <= 12'd0;
            inst_r  <= 32'd0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            rd_r    <= rd_s;
            lo_r    <= lo_s;
            inst_r  <= inst_s;
            valid_r <= valid_s;
            last_r  <= last_s;
        end
    end

endmodule

// File: tb/tb_li_expander.sv
// Bench for li_expander: directed cases, backpressure, mid-sequence reset and random
// requests against an arithmetic reference model, on OPT_SHORT=1 and OPT_SHORT=0 instances.
module tb_li_expander;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        tb_valid = 1'b0;
    logic        tb_ready = 1'b0;
    logic [4:0]  tb_rd = 5'd0;
    logic [31:0] tb_value = 32'd0;

    logic        ra, rb, va, vb, la, lb;
    logic [31:0] ia, ib;
    logic        obs_ready, obs_valid, obs_last;
    logic [31:0] obs_inst;

    int tests = 0;
    int fails = 0;

    always #5 i_clk = ~i_clk;

    li_expander dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(tb_valid & ~sel), .o_ready(ra),
        .i_rd(tb_rd), .i_value(tb_value),
        .o_valid(va), .i_ready(tb_ready & ~sel),
        .o_inst(ia), .o_last(la)
    );

    li_expander #(.OPT_SHORT(1'b0)) dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(tb_valid & sel), .o_ready(rb),
        .i_rd(tb_rd), .i_value(tb_value),
        .o_valid(vb), .i_ready(tb_ready & sel),
        .o_inst(ib), .o_last(lb)
    );

    assign obs_ready = sel ? rb : ra;
    assign obs_valid = sel ? vb : va;
    assign obs_last  = sel ? lb : la;
    assign obs_inst  = sel ? ib : ia;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: value split by plain arithmetic, form chosen by numeric range.
    function automatic int build(input logic [4:0] rd, input logic [31:0] v, input bit short,
                                 output logic [31:0] e0, output logic [31:0] e1);
        int          sv;
        logic [31:0] lo32, hi32, r32;
        sv   = $signed(v);
        lo32 = v & 32'h0000_0FFF;
        hi32 = (v + 32'h0000_0800) >> 12;
        r32  = 32'(rd);
        e1   = 32'd0;
        if (rd == 5'd0) begin
            e0 = 32'h0000_0013;
            return 1;
        end
        if (short && sv >= -2048 && sv <= 2047) begin
            e0 = (lo32 << 20) | (r32 << 7) | 32'h13;
            return 1;
        end
        e0 = (hi32 << 12) | (r32 << 7) | 32'h37;
        if (short && lo32 == 32'd0) return 1;
        e1 = (lo32 << 20) | (r32 << 15) | (r32 << 7) | 32'h13;
        return 2;
    endfunction

    task automatic do_req(input bit s, input logic [4:0] rd, input logic [31:0] v, input int stall0);
        logic [31:0] e [2];
        int          n, w, stalls;
        sel = s;
        n = build(rd, v, !s, e[0], e[1]);
        w = 0;
        while (!obs_ready && w < 8) begin
            @(posedge i_clk); @(negedge i_clk);
            w++;
        end
        chk("ready_before_accept", {31'd0, obs_ready}, 32'd1);
        tb_rd = rd; tb_value = v; tb_valid = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        tb_valid = 1'b0; tb_rd = 5'($urandom); tb_value = $urandom;
        for (int k = 0; k < n; k++) begin
            stalls = (k == 0 && stall0 >= 0) ? stall0 : int'($urandom_range(0, 2));
            for (int st = 0; st < stalls; st++) begin
                tb_ready = 1'b0;
                tb_valid = 1'b1;
                chk("stall_valid", {31'd0, obs_valid}, 32'd1);
                chk("stall_inst", obs_inst, e[k]);
                chk("stall_last", {31'd0, obs_last}, {31'd0, (k == n - 1)});
                chk("stall_ready", {31'd0, obs_ready}, 32'd0);
                @(posedge i_clk); @(negedge i_clk);
            end
            tb_valid = 1'b0;
            tb_ready = 1'b1;
            chk("beat_valid", {31'd0, obs_valid}, 32'd1);
            chk("beat_inst", obs_inst, e[k]);
            chk("beat_last", {31'd0, obs_last}, {31'd0, (k == n - 1)});
            chk("beat_ready", {31'd0, obs_ready}, 32'd0);
            @(posedge i_clk); @(negedge i_clk);
            tb_ready = 1'b0;
        end
        chk("end_valid", {31'd0, obs_valid}, 32'd0);
        chk("end_last", {31'd0, obs_last}, 32'd0);
        chk("end_ready", {31'd0, obs_ready}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [4:0]  rd;
        int          mode;

        repeat (2) @(negedge i_clk);
        chk("rst_valid", {31'd0, obs_valid}, 32'd0);
        chk("rst_inst", obs_inst, 32'd0);
        chk("rst_last", {31'd0, obs_last}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_ready", {31'd0, obs_ready}, 32'd1);

        do_req(1'b0, 5'd5,  32'h0000_0123, 0);
        do_req(1'b0, 5'd10, 32'h1234_5000, 1);
        do_req(1'b0, 5'd1,  32'h1234_5FFF, 3);
        do_req(1'b0, 5'd2,  32'hFFFF_F800, 0);
        do_req(1'b1, 5'd2,  32'hFFFF_F800, 0);
        do_req(1'b0, 5'd0,  32'hDEAD_BEEF, 2);
        do_req(1'b1, 5'd0,  32'h0000_0123, 0);
        do_req(1'b0, 5'd31, 32'h0000_07FF, 0);
        do_req(1'b0, 5'd31, 32'h0000_0800, 0);
        do_req(1'b0, 5'd7,  32'h8000_0000, 0);

        // Reset while the ADDI beat is pending.
        sel = 1'b0;
        tb_rd = 5'd1; tb_value = 32'h1234_5FFF; tb_valid = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        tb_valid = 1'b0; tb_ready = 1'b1;
        chk("rr_beat1", obs_inst, 32'h1234_60B7);
        @(posedge i_clk); @(negedge i_clk);
        tb_ready = 1'b0;
        chk("rr_beat2", obs_inst, 32'hFFF0_8093);
        chk("rr_valid2", {31'd0, obs_valid}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("rr_valid_drop", {31'd0, obs_valid}, 32'd0);
        chk("rr_last_drop", {31'd0, obs_last}, 32'd0);
        chk("rr_inst_clear", obs_inst, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rr_ready", {31'd0, obs_ready}, 32'd1);
        do_req(1'b0, 5'd1, 32'h1234_5FFF, 0);

        for (int t = 0; t < 80; t++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: v = $urandom;
                1: v = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: v = $urandom & 32'hFFFF_F000;
                default: v = 32'h0000_07FE + 32'($urandom_range(0, 3)) + ($urandom & 32'hFFFF_F000);
            endcase
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            do_req(1'($urandom), rd, v, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
